// File: rtl/rvm_pcu_pkg.sv
// Shared encodings for the RISC-V program counter / fetch unit: next-PC selects,
// FSM state codes, trap cause codes and the next-PC helper.
package rvm_pcu_pkg;

    localparam logic [1:0] RVM_PCU_SEL_SEQ    = 2'b00;
    localparam logic [1:0] RVM_PCU_SEL_BRANCH = 2'b01;
    localparam logic [1:0] RVM_PCU_SEL_MEPC   = 2'b10;

    localparam logic [2:0] RVM_PCU_ST_REQ   = 3'd0;
    localparam logic [2:0] RVM_PCU_ST_WAIT  = 3'd1;
    localparam logic [2:0] RVM_PCU_ST_HOLD  = 3'd2;
    localparam logic [2:0] RVM_PCU_ST_DRAIN = 3'd3;
    localparam logic [2:0] RVM_PCU_ST_TRAP  = 3'd4;

    localparam logic RVM_PCU_CAUSE_MISALIGN = 1'b0;
    localparam logic RVM_PCU_CAUSE_FAULT    = 1'b1;

    typedef enum logic [2:0] {
        ST_REQ   = RVM_PCU_ST_REQ,
        ST_WAIT  = RVM_PCU_ST_WAIT,
        ST_HOLD  = RVM_PCU_ST_HOLD,
        ST_DRAIN = RVM_PCU_ST_DRAIN,
        ST_TRAP  = RVM_PCU_ST_TRAP
    } pcu_state_e;

    // Select 2'b11 is reserved and falls back to sequential execution.
    function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                            input logic [1:0]  sel,
                                            input logic [31:0] branch_target,
                                            input logic [31:0] mepc);
        case (sel)
            RVM_PCU_SEL_BRANCH: next_pc = branch_target;
            RVM_PCU_SEL_MEPC:   next_pc = mepc;
            default:            next_pc = pc + 32'd4;
        endcase
    endfunction

endpackage

// File: rtl/rvm_pcu.sv
// Program counter and single-outstanding instruction fetch unit. Holds the PC,
// fetches one word at a time, computes the next PC on retirement, reports fetch traps.
module rvm_pcu
    import rvm_pcu_pkg::*;
#(
    parameter logic [31:0] RVM_PCU_RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_error,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        advance,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] branch_target,
    input  logic        goto_mtvec,
    input  logic [31:2] mtvec,
    input  logic [31:0] mepc,
    output logic [31:0] pc,
    output logic        instr_retired,
    output logic        trap_iaddr_misalign,
    output logic        trap_iaddr_fault,
    output logic        ld_bad_addr,
    output logic [31:0] bad_addr_val
);

    pcu_state_e state;
    logic       cause;
    logic       pc_aligned;

    assign pc_aligned = (pc[1:0] == 2'b00);

    // Everything the SCU feeds back on (trap lines, ld_bad_addr) comes from
    // registered state only, so goto_mtvec can never close a combinational loop.
    assign imem_req            = !reset && (state == ST_REQ) && pc_aligned;
    assign imem_addr           = pc;
    assign instr_valid         = (state == ST_HOLD);
    assign ld_bad_addr         = (state == ST_TRAP);
    assign trap_iaddr_misalign = (state == ST_TRAP) && (cause == RVM_PCU_CAUSE_MISALIGN);
    assign trap_iaddr_fault    = (state == ST_TRAP) && (cause == RVM_PCU_CAUSE_FAULT);
    assign bad_addr_val        = pc;
    assign instr_retired       = !reset && (state == ST_HOLD) && advance && !goto_mtvec;

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would leak new pc into the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_REQ;
            pc    <= RVM_PCU_RESET_PC;
            instr <= 32'h0;
            cause <= RVM_PCU_CAUSE_MISALIGN;
        end else if (goto_mtvec) begin
            // Redirect beats everything; an in-flight fetch must still be drained.
            pc <= {mtvec, 2'b00};
            if ((state == ST_WAIT || state == ST_DRAIN) && !imem_rvalid)
                state <= ST_DRAIN;
            else
                state <= ST_REQ;
        end else begin
            case (state)
                ST_REQ: begin
                    if (!pc_aligned) begin
                        state <= ST_TRAP;
                        cause <= RVM_PCU_CAUSE_MISALIGN;
                    end else if (imem_gnt) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        if (imem_error) begin
                            state <= ST_TRAP;
                            cause <= RVM_PCU_CAUSE_FAULT;
                        end else begin
                            instr <= imem_rdata;
                            state <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (advance) begin
                        pc    <= next_pc(pc, pc_sel, branch_target, mepc);
                        state <= ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rvalid)
                        state <= ST_REQ;
                end
                ST_TRAP: state <= ST_TRAP;
                default: state <= ST_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_rvm_pcu.sv
// Directed self-checking bench for rvm_pcu: fetch sequencing, traps, redirects,
// simultaneous events and reset in the middle of a fetch.
module tb_rvm_pcu;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_error;
    logic [31:0] instr;
    logic        instr_valid;
    logic        advance;
    logic [1:0]  pc_sel;
    logic [31:0] branch_target;
    logic        goto_mtvec;
    logic [31:2] mtvec;
    logic [31:0] mepc;
    logic [31:0] pc;
    logic        instr_retired;
    logic        trap_iaddr_misalign;
    logic        trap_iaddr_fault;
    logic        ld_bad_addr;
    logic [31:0] bad_addr_val;

    int errors = 0;
    int checks = 0;

    rvm_pcu #(.RVM_PCU_RESET_PC(32'h0000_0000)) dut (
        .clk                 (clk),
        .reset               (reset),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_gnt            (imem_gnt),
        .imem_rvalid         (imem_rvalid),
        .imem_rdata          (imem_rdata),
        .imem_error          (imem_error),
        .instr               (instr),
        .instr_valid         (instr_valid),
        .advance             (advance),
        .pc_sel              (pc_sel),
        .branch_target       (branch_target),
        .goto_mtvec          (goto_mtvec),
        .mtvec               (mtvec),
        .mepc                (mepc),
        .pc                  (pc),
        .instr_retired       (instr_retired),
        .trap_iaddr_misalign (trap_iaddr_misalign),
        .trap_iaddr_fault    (trap_iaddr_fault),
        .ld_bad_addr         (ld_bad_addr),
        .bad_addr_val        (bad_addr_val)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance one cycle and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch starting in REQ; ends in HOLD with the word presented.
    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] data);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin
            errors++;
            $display("FAIL fetch_req: req=%b addr=%h, want req=1 addr=%h", imem_req, imem_addr, exp_addr);
        end
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_error  = 1'b0;
        imem_rdata  = data;
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instr !== data) begin
            errors++;
            $display("FAIL fetch_hold: valid=%b instr=%h, want valid=1 instr=%h", instr_valid, instr, data);
        end
    endtask

    // Retire the held instruction with the given next-PC source.
    task automatic retire(input logic [1:0] sel, input logic [31:0] target, input logic [31:0] exp_pc);
        advance       = 1'b1;
        pc_sel        = sel;
        branch_target = target;
        #1;
        checks++;
        if (instr_retired !== 1'b1) begin
            errors++;
            $display("FAIL retire_pulse: got %b want 1", instr_retired);
        end
        tick();
        advance = 1'b0;
        checks++;
        if (instr_retired !== 1'b0 || instr_valid !== 1'b0 || pc !== exp_pc) begin
            errors++;
            $display("FAIL retire_next: retired=%b valid=%b pc=%h, want 0 0 %h", instr_retired, instr_valid, pc, exp_pc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        advance = 1'b1;
        tick();
        tick();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_core: req=%b valid=%b instr=%h pc=%h, want 0 0 0 0", imem_req, instr_valid, instr, pc);
        end
        checks++;
        if (trap_iaddr_misalign !== 1'b0 || trap_iaddr_fault !== 1'b0 || ld_bad_addr !== 1'b0 || instr_retired !== 1'b0) begin
            errors++;
            $display("FAIL reset_traps: mis=%b flt=%b ld=%b ret=%b, want all 0", trap_iaddr_misalign, trap_iaddr_fault, ld_bad_addr, instr_retired);
        end
        advance = 1'b0;
        reset   = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_release: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [1:0] sels [3] = '{2'b00, 2'b00, 2'b11};
        for (int i = 0; i < 3; i++) begin
            do_fetch(32'(i * 4), 32'h0000_0013);
            retire(sels[i], 32'hFFFF_FFF0, 32'(i * 4 + 4));
        end
    endtask

    task automatic test_misalign();
        do_fetch(32'h0000_000C, 32'h0000_0013);
        retire(2'b01, 32'h0000_0102, 32'h0000_0102);
        checks++;
        if (imem_req !== 1'b0 || ld_bad_addr !== 1'b0) begin
            errors++;
            $display("FAIL misalign_noreq: req=%b ld=%b, want 0 0", imem_req, ld_bad_addr);
        end
        tick();
        tick();
        checks++;
        if (trap_iaddr_misalign !== 1'b1 || trap_iaddr_fault !== 1'b0 || ld_bad_addr !== 1'b1 ||
            bad_addr_val !== 32'h0000_0102 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL misalign_trap: mis=%b flt=%b ld=%b bad=%h req=%b, want 1 0 1 00000102 0",
                     trap_iaddr_misalign, trap_iaddr_fault, ld_bad_addr, bad_addr_val, imem_req);
        end
        goto_mtvec = 1'b1;
        mtvec      = 30'(32'h1C0 >> 2);
        tick();
        goto_mtvec = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_01C0 || trap_iaddr_misalign !== 1'b0 || ld_bad_addr !== 1'b0) begin
            errors++;
            $display("FAIL misalign_vector: req=%b addr=%h mis=%b ld=%b, want 1 000001c0 0 0",
                     imem_req, imem_addr, trap_iaddr_misalign, ld_bad_addr);
        end
    endtask

    task automatic test_fault();
        do_fetch(32'h0000_01C0, 32'h0000_0013);
        retire(2'b01, 32'h0000_0040, 32'h0000_0040);
        imem_gnt = 1'b1;
        tick();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_error  = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        imem_error  = 1'b0;
        checks++;
        if (trap_iaddr_fault !== 1'b1 || trap_iaddr_misalign !== 1'b0 || ld_bad_addr !== 1'b1 ||
            bad_addr_val !== 32'h0000_0040 || instr !== 32'h0000_0013) begin
            errors++;
            $display("FAIL fault_trap: flt=%b mis=%b ld=%b bad=%h instr=%h, want 1 0 1 00000040 00000013",
                     trap_iaddr_fault, trap_iaddr_misalign, ld_bad_addr, bad_addr_val, instr);
        end
        goto_mtvec = 1'b1;
        tick();
        goto_mtvec = 1'b0;
        checks++;
        if (trap_iaddr_fault !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_01C0) begin
            errors++;
            $display("FAIL fault_refetch: flt=%b req=%b addr=%h, want 0 1 000001c0", trap_iaddr_fault, imem_req, imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        imem_gnt = 1'b1;
        tick();
        imem_gnt   = 1'b0;
        goto_mtvec = 1'b1;
        mtvec      = 30'(32'h300 >> 2);
        tick();
        checks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h0000_0300) begin
            errors++;
            $display("FAIL drain_enter: req=%b valid=%b pc=%h, want 0 0 00000300", imem_req, instr_valid, pc);
        end
        mtvec = 30'(32'h1C0 >> 2);
        tick();
        goto_mtvec = 1'b0;
        checks++;
        if (pc !== 32'h0000_01C0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL drain_last_wins: pc=%h req=%b, want 000001c0 0", pc, imem_req);
        end
        tick();
        imem_rvalid = 1'b1;
        imem_error  = 1'b1;
        imem_rdata  = 32'hBAAD_F00D;
        tick();
        imem_rvalid = 1'b0;
        imem_error  = 1'b0;
        checks++;
        if (trap_iaddr_fault !== 1'b0 || ld_bad_addr !== 1'b0 || instr_valid !== 1'b0 ||
            instr !== 32'h0000_0013 || imem_req !== 1'b1 || imem_addr !== 32'h0000_01C0) begin
            errors++;
            $display("FAIL drain_exit: flt=%b ld=%b valid=%b instr=%h req=%b addr=%h, want 0 0 0 00000013 1 000001c0",
                     trap_iaddr_fault, ld_bad_addr, instr_valid, instr, imem_req, imem_addr);
        end
    endtask

    task automatic test_simultaneous();
        do_fetch(32'h0000_01C0, 32'h0000_0013);
        retire(2'b01, 32'h0000_0020, 32'h0000_0020);
        do_fetch(32'h0000_0020, 32'h0000_0033);
        advance    = 1'b1;
        pc_sel     = 2'b00;
        goto_mtvec = 1'b1;
        #1;
        checks++;
        if (instr_retired !== 1'b0) begin
            errors++;
            $display("FAIL simul_retired: got %b want 0", instr_retired);
        end
        tick();
        advance    = 1'b0;
        goto_mtvec = 1'b0;
        checks++;
        if (pc !== 32'h0000_01C0 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL simul_redirect: pc=%h valid=%b req=%b, want 000001c0 0 1", pc, instr_valid, imem_req);
        end
        do_fetch(32'h0000_01C0, 32'h3020_0073);
        mepc = 32'h0000_0024;
        retire(2'b10, 32'h0000_0000, 32'h0000_0024);
        checks++;
        if (imem_addr !== 32'h0000_0024 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL mret_fetch: addr=%h req=%b, want 00000024 1", imem_addr, imem_req);
        end
    endtask

    task automatic test_reset_midfetch();
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        reset    = 1'b1;
        tick();
        checks++;
        if (pc !== 32'h0 || imem_req !== 1'b0 || instr !== 32'h0) begin
            errors++;
            $display("FAIL midreset_state: pc=%h req=%b instr=%h, want 00000000 0 00000000", pc, imem_req, instr);
        end
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL midreset_fresh_req: req=%b addr=%h, want 1 00000000", imem_req, imem_addr);
        end
        tick();
        imem_rvalid = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0 || imem_req !== 1'b1) begin
            errors++;
            $display("FAIL midreset_stale: valid=%b instr=%h req=%b, want 0 00000000 1", instr_valid, instr, imem_req);
        end
        do_fetch(32'h0, 32'h0000_0013);
    endtask

    initial begin
        reset         = 1'b1;
        imem_gnt      = 1'b0;
        imem_rvalid   = 1'b0;
        imem_rdata    = 32'h0;
        imem_error    = 1'b0;
        advance       = 1'b0;
        pc_sel        = 2'b00;
        branch_target = 32'h0;
        goto_mtvec    = 1'b0;
        mtvec         = 30'h0;
        mepc          = 32'h0;

        test_reset();
        test_sequential();
        test_misalign();
        test_fault();
        test_redirect_wait();
        test_simultaneous();
        test_reset_midfetch();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
